// File: rtl/shift_acc_sequencer.sv
// rtl/shift_acc_sequencer.sv - product realign/accumulate sequencer with valid/ready term and result handshakes
// Optional ACC_SAT_EN: saturating accumulator with sticky ovf; otherwise the sum wraps and ovf is 0.
module shift_acc_sequencer #(
  parameter int A_BW    = 8,
  parameter int B_BW    = 8,
  parameter int MULT_DW = 6,
  parameter int LEN     = 16,
  parameter int ACC_W   = A_BW + B_BW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(LEN):0]     len_cfg,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*MULT_DW-1:0]     mult_out,
  input  logic [$clog2(B_BW):0]    shift_amt,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     ovf
);

  localparam int LW = $clog2(LEN) + 1;
  localparam int PW = A_BW + B_BW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [LW-1:0]     len_q, cnt;
  logic [ACC_W-1:0]  acc, term, acc_sum;
  logic [PW-1:0]     prod_w;
  logic              accept, last, job_start;

  // Realign: widen to the full product width first so high bits shift out there.
  assign prod_w    = PW'(mult_out);
  assign term      = ACC_W'(prod_w << shift_amt);
  assign accept    = (state == RUN) && in_valid;
  assign last      = (cnt == len_q - LW'(1));
  assign job_start = (state == IDLE) && start;
  assign acc_out   = acc;

`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           ovf_q;

  assign sum_wide = {1'b0, acc} + {1'b0, term};
  assign acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign ovf      = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         ovf_q <= 1'b0;
    else if (job_start)              ovf_q <= 1'b0;
    else if (accept && sum_wide[ACC_W]) ovf_q <= 1'b1;
  end
`else
  assign acc_sum = acc + term;
  assign ovf     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len_cfg == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else if (job_start) begin
      len_q <= len_cfg;
      cnt   <= '0;
      acc   <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt + LW'(1);
    end
  end

endmodule

// File: tb/tb_shift_acc_sequencer.sv
// tb/tb_shift_acc_sequencer.sv - directed self-checking bench for shift_acc_sequencer
module tb_shift_acc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  len_cfg = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] mult_out = '0;
  logic [3:0]  shift_amt = '0;
  logic [15:0] acc_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        ovf;

  int n_pass = 0;
  int n_total = 0;

  shift_acc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len_cfg(len_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .mult_out(mult_out),
    .shift_amt(shift_amt), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Every task starts and ends on a falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_job(input logic [4:0] len);
    start = 1'b1;
    len_cfg = len;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [11:0] m, input logic [3:0] s);
    in_valid = 1'b1;
    mult_out = m;
    shift_amt = s;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  logic [15:0] exp_acc;
  logic        exp_ovf;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_acc", acc_out, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    cyc();

    // Shift and truncate
    begin_job(5'd3);
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 1);
    send(12'h03F, 4'd2);
    send(12'h001, 4'd0);
    check("t1_no_valid_early", out_valid, 0);
    send(12'h800, 4'd5);
    check("t1_out_valid", out_valid, 1);
    check("t1_acc", acc_out, 16'h00FD);
    check("t1_in_ready_drop", in_ready, 0);
    consume();
    check("t1_idle_valid", out_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_acc_kept", acc_out, 16'h00FD);

    // Stalls and backpressure
    begin_job(5'd3);
    send(12'h03F, 4'd2);
    cyc();
    cyc();
    check("t2_stall_ready", in_ready, 1);
    check("t2_stall_acc", acc_out, 16'h00FC);
    send(12'h001, 4'd0);
    send(12'h800, 4'd5);
    for (int i = 0; i < 4; i++) begin
      check("t2_wait_valid", out_valid, 1);
      check("t2_wait_acc", acc_out, 16'h00FD);
      cyc();
    end
    check("t2_still_valid", out_valid, 1);
    consume();
    check("t2_idle_valid", out_valid, 0);
    check("t2_idle_busy", busy, 0);

    // Overflow
`ifdef ACC_SAT_EN
    exp_acc = 16'hFFFF;
    exp_ovf = 1'b1;
`else
    exp_acc = 16'hFFE0;
    exp_ovf = 1'b0;
`endif
    begin_job(5'd2);
    send(12'hFFF, 4'd4);
    send(12'hFFF, 4'd4);
    check("t3_valid", out_valid, 1);
    check("t3_acc", acc_out, exp_acc);
    check("t3_ovf", ovf, exp_ovf);
    consume();

    // Zero length
    start = 1'b1;
    len_cfg = 5'd0;
    @(posedge clk);
    #1 check("t4_no_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    check("t4_valid", out_valid, 1);
    check("t4_in_ready", in_ready, 0);
    check("t4_acc", acc_out, 0);
    check("t4_ovf_clr", ovf, 0);
    consume();
    check("t4_idle", busy, 0);

    // Ignored start during RUN
    begin_job(5'd4);
    send(12'h001, 4'd0);
    start = 1'b1;
    len_cfg = 5'd2;
    send(12'h002, 4'd0);
    start = 1'b0;
    check("t5_still_run", in_ready, 1);
    check("t5_acc_mid", acc_out, 16'h0003);
    send(12'h003, 4'd0);
    check("t5_no_early_done", out_valid, 0);
    send(12'h004, 4'd0);
    check("t5_valid", out_valid, 1);
    check("t5_acc", acc_out, 16'h000A);
    consume();

    // Reset mid-job
    begin_job(5'd4);
    send(12'h011, 4'd0);
    send(12'h022, 4'd0);
    rst = 1'b1;
    #1;
    check("t6_acc", acc_out, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    begin_job(5'd1);
    send(12'h005, 4'd1);
    check("t6_new_valid", out_valid, 1);
    check("t6_new_acc", acc_out, 16'h000A);
    consume();
    check("t6_end_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
